// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the 4-channel scan controller.
package scan_ctrl_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BLANK  = 2'b01,
    ACTIVE = 2'b10
  } state_t;
endpackage

// File: rtl/scan_next_ch.sv
// Combinational search for the next enabled channel strictly after i_cur, wrapping;
// i_cur itself is the last candidate. o_wrap flags next <= current, o_none an empty mask.
module scan_next_ch
  import scan_ctrl_pkg::*;
(
  input  logic [CH_W-1:0]   i_cur,
  input  logic [NUM_CH-1:0] i_mask,
  output logic [CH_W-1:0]   o_nxt,
  output logic              o_wrap,
  output logic              o_none
);

  logic [CH_W-1:0] w_idx;

  always_comb begin
    o_nxt  = i_cur;
    o_none = (i_mask == '0);
    w_idx  = '0;
    // Walk from farthest to nearest so the closest enabled channel wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = i_cur + CH_W'(k);
      if (i_mask[w_idx]) o_nxt = w_idx;
    end
    o_wrap = (o_nxt <= i_cur);
  end

endmodule

// File: rtl/scan_ctrl4.sv
// Scans a 2-bit decoder select over enabled channels with a blanking gap before each dwell.
// Optional macro SCAN_CTRL_HOLD_EN adds a hold input that freezes the blank/dwell counters.
module scan_ctrl4
  import scan_ctrl_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
`ifdef SCAN_CTRL_HOLD_EN
  input  logic             hold,
`endif
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       mask,
  output logic             a,
  output logic             b,
  output logic             en,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CH_W-1:0]  r_sel;
  logic [CH_W-1:0]  w_sel_nxt;
  logic             r_en;
  logic             w_en_nxt;
  logic             r_fd;
  logic             w_fd_nxt;
  logic [7:0]       r_blank_cnt;
  logic [7:0]       w_blank_nxt;
  logic [DIV_W-1:0] r_dwell_cnt;
  logic [DIV_W-1:0] w_dwell_nxt;
  logic             r_empty;
  logic             w_empty_nxt;
  logic             w_hold;
  logic [CH_W-1:0]  w_cur;
  logic [CH_W-1:0]  w_nxt_ch;
  logic             w_wrap;
  logic             w_none;

`ifdef SCAN_CTRL_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  // From IDLE search after the top channel, which yields the lowest enabled one.
  assign w_cur = (r_state == IDLE) ? CH_W'(NUM_CH - 1) : r_sel;

  scan_next_ch u_next (
    .i_cur  (w_cur),
    .i_mask (mask),
    .o_nxt  (w_nxt_ch),
    .o_wrap (w_wrap),
    .o_none (w_none)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_en        <= 1'b0;
      r_fd        <= 1'b0;
      r_blank_cnt <= '0;
      r_dwell_cnt <= '0;
      r_empty     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_en        <= w_en_nxt;
      r_fd        <= w_fd_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_empty     <= w_empty_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_en_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_blank_nxt = r_blank_cnt;
    w_dwell_nxt = r_dwell_cnt;
    w_empty_nxt = r_empty;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = BLANK;
          w_blank_nxt = '0;
          w_empty_nxt = w_none;
          w_sel_nxt   = w_none ? '0 : w_nxt_ch;
        end
      end
      BLANK: begin
        if (r_empty) begin
          // Parked on an empty mask: resume after the held channel, fresh blank gap.
          if (!w_none) begin
            w_sel_nxt   = w_nxt_ch;
            w_empty_nxt = 1'b0;
            w_blank_nxt = '0;
          end
        end else if (!w_hold) begin
          if (r_blank_cnt == BLANK_LAST) begin
            w_state_nxt = ACTIVE;
            w_dwell_nxt = div;
            w_en_nxt    = 1'b1;
          end else begin
            w_blank_nxt = r_blank_cnt + 8'd1;
          end
        end
      end
      ACTIVE: begin
        w_en_nxt = 1'b1;
        if (!w_hold) begin
          if (r_dwell_cnt == '0) begin
            w_en_nxt    = 1'b0;
            w_state_nxt = BLANK;
            w_blank_nxt = '0;
            if (w_none) begin
              w_empty_nxt = 1'b1;
            end else begin
              w_sel_nxt = w_nxt_ch;
              w_fd_nxt  = w_wrap;
            end
          end else begin
            w_dwell_nxt = r_dwell_cnt - DIV_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (stop) begin
      w_state_nxt = IDLE;
      w_en_nxt    = 1'b0;
      w_fd_nxt    = 1'b0;
      w_empty_nxt = 1'b0;
    end
  end

  assign a          = r_sel[1];
  assign b          = r_sel[0];
  assign en         = r_en;
  assign frame_done = r_fd;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_scan_ctrl4.sv
// Directed self-checking bench for scan_ctrl4; cycle n is the interval after edge n-1,
// edge 0 being the one that samples the start pulse.
module tb_scan_ctrl4;
  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] div;
  logic [3:0]  mask;
  logic        a, b, en, busy, frame_done;
`ifdef SCAN_CTRL_HOLD_EN
  logic        hold = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_ctrl4 #(.DIV_W(16), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef SCAN_CTRL_HOLD_EN
    .hold       (hold),
`endif
    .div        (div),
    .mask       (mask),
    .a          (a),
    .b          (b),
    .en         (en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {busy,en,a,b,frame_done} against an expected vector.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {busy, en, a, b, frame_done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={busy,en,a,b,fd}=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] vec(input logic bsy, input logic e,
                                     input logic [1:0] s, input logic fd);
    return {bsy, e, s, fd};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; div = 16'd3; mask = 4'b1111;
    tick(); tick();
    chk("reset", 5'b00000);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 5'b00000);

    // Basic scan, all channels, div=3: 6-cycle slot per channel, 24-cycle frame.
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      int pos;
      pos = (c - 1) % 24;
      chk($sformatf("basic_c%0d", c),
          vec(1'b1, (pos % 6) >= 2, 2'(pos / 6), (pos == 0) && (c > 1)));
      tick();
    end
    // Cycle 27 is ch0 active; stop drops en and busy on the next edge, sel held.
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_mid_active", 5'b00000);

    // Skip: channels 1 and 3 only, div=0.
    mask = 4'b1010; div = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      int pos;
      pos = (c - 1) % 6;
      chk($sformatf("skip_c%0d", c),
          vec(1'b1, (pos % 3) == 2, (pos < 3) ? 2'd1 : 2'd3, (pos == 0) && (c > 1)));
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("skip_stop_holds_sel", 5'b00010);

    // Single channel 2, div=1: frame_done after every dwell.
    mask = 4'b0100; div = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      int pos;
      pos = (c - 1) % 4;
      chk($sformatf("single_c%0d", c),
          vec(1'b1, pos >= 2, 2'd2, (pos == 0) && (c > 1)));
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("single_stop", 5'b00100);

    // Empty mask during ch1 dwell.
    mask = 4'b1111; div = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    chk("empty_c10_ch1_active", 5'b11010);
    mask = 4'b0000;
    tick(); tick();
    chk("empty_c12_dwell_intact", 5'b11010);
    tick();
    chk("empty_c13_parked", 5'b10010);
    repeat (10) tick();
    chk("empty_c23_still_parked", 5'b10010);
    mask = 4'b0001;
    tick();
    chk("empty_c24_resel_blank", 5'b10000);
    tick();
    chk("empty_c25_blank", 5'b10000);
    tick();
    chk("empty_c26_ch0_active", 5'b11000);
    repeat (4) tick();
    chk("empty_c30_wrap_fd", 5'b10001);
    rst = 1'b1; tick();
    chk("rst_mid_blank", 5'b00000);
    rst = 1'b0;

    // start and stop together from IDLE: stop wins.
    mask = 4'b1111;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_same", 5'b00000);
    tick();
    chk("start_stop_same_later", 5'b00000);

    // Start with an empty mask, then enable channel 2.
    mask = 4'b0000; div = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_empty_c1", 5'b10000);
    tick(); tick();
    chk("start_empty_c3", 5'b10000);
    mask = 4'b0100;
    tick();
    chk("start_empty_c4_sel2", 5'b10100);
    tick();
    chk("start_empty_c5_blank", 5'b10100);
    tick();
    chk("start_empty_c6_active", 5'b11100);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("start_empty_stop", 5'b00100);

`ifdef SCAN_CTRL_HOLD_EN
    // Hold 10 cycles during ch2 dwell (div=3): en high cycles 15..28.
    mask = 4'b1111; div = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    chk("hold_c15_ch2_active", 5'b11100);
    tick();
    hold = 1'b1;
    repeat (10) tick();
    hold = 1'b0;
    chk("hold_c26_still_active", 5'b11100);
    tick(); tick();
    chk("hold_c28_last_dwell", 5'b11100);
    tick();
    chk("hold_c29_ch3_blank", 5'b10110);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("hold_stop", 5'b00110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_ctrl4.md
Name: scan_ctrl4

Overview:
Upstream driver for the team's 2-to-4 decoder with enable. Cycles a 2-bit channel select {a,b} through the four decoder outputs in ascending order and skips masked channels. Each channel dwells for a programmable time, and a blanking gap with en low separates channels so there is no ghosting on the one-hot outputs. Typical use: multiplexed display digits or row strobes.

Parameters:
DIV_W, 16, width of the dwell-length input div.
BLANK_CYC, 2, cycles en is held low before each dwell; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  single-cycle pulse; begins scanning from IDLE.
stop  input  1  single-cycle pulse; returns to IDLE.
div  input  DIV_W  dwell length minus one, in cycles; sampled on entry to ACTIVE.
mask  input  4  channel enable mask; bit i enables channel i; sampled at each channel selection.
a  output  1  select MSB (channel index = {a,b}); registered.
b  output  1  select LSB; registered.
en  output  1  decoder enable; high only in ACTIVE; registered.
busy  output  1  high whenever state is not IDLE.
frame_done  output  1  one-cycle pulse per completed scan frame.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, a=0, b=0, en=0, busy=0, frame_done=0, counters 0. rst mid-scan aborts on the next edge.
- States: IDLE, BLANK, ACTIVE. All outputs are registered, so each changes on the edge where its state is entered.
- IDLE:
  - start=1 with mask!=0 -> select the lowest enabled channel, go to BLANK.
  - start=1 with mask=0 -> go to BLANK holding sel=0 (mask-empty wait, below).
  - start while not IDLE is ignored.
- BLANK:
  - en=0; count BLANK_CYC cycles, then go to ACTIVE and latch div into the dwell counter.
- ACTIVE:
  - en=1; dwell lasts div+1 cycles (div=0 gives 1 cycle).
  - At dwell end: en=0, {a,b} moves to the next enabled channel above the current one, wrapping 3->0, and state goes to BLANK.
  - en falls and sel changes on the same edge.
- Frame wrap:
  - When the next channel index <= the current index (wrap, or a single enabled channel), frame_done=1 during the first cycle of the following BLANK.
- Mask empty at a selection point:
  - Stay in BLANK with en=0 and sel held.
  - When mask goes nonzero, select the next enabled channel after the held one and restart the BLANK count.
  - No frame_done is produced in this case.
- Stop:
  - stop=1 -> IDLE on the next edge with en=0; a and b keep their last values.
  - start and stop in the same cycle: stop wins.
- Mask changes during ACTIVE do not truncate the current dwell.

Optional Feature:
Macro SCAN_CTRL_HOLD_EN.
- Defined: adds input port hold (1 bit).
  - While hold=1 in ACTIVE, the dwell counter freezes, en stays 1, and sel does not advance.
  - In BLANK, the blank counter freezes.
  - stop and rst override hold.
- Undefined: the port is absent and behaviour is identical to hold=0.

Decomposition:
- Package scan_ctrl_pkg:
  - state enum typedef: IDLE=2'b00, BLANK=2'b01, ACTIVE=2'b10.
  - NUM_CH=4 and CH_W=2.
- Sub-module scan_next_ch (combinational):
  - inputs: current index, mask.
  - outputs: next enabled index (wrapping), wrap flag, none-enabled flag.
  - Used for both the start and advance decisions.

Test Plan:
- Basic scan: BLANK_CYC=2, div=3, mask=4'b1111, start pulse at edge 0.
  - Cycles 1-2: en=0, {a,b}=00; cycles 3-6: en=1, {a,b}=00.
  - {a,b}=01 active at cycles 9-12; frame period 24 cycles.
  - frame_done high at cycle 25.
- Skip: mask=4'b1010, div=0 -> active sequence {a,b}=01,11,01,11; en high 1 cycle per 3; frame_done once per 6 cycles.
- Single channel: mask=4'b0100 -> {a,b} stays 10; frame_done after every dwell.
- Empty mask: clear mask to 0 mid-ACTIVE on channel 1.
  - Dwell completes; en stays 0 indefinitely.
  - Set mask=4'b0001 -> after 2 BLANK cycles, ch0 becomes active.
- Control collisions:
  - start+stop in the same cycle from IDLE -> stays IDLE, busy=0.
  - stop mid-ACTIVE -> en=0 and busy=0 on the next edge.
  - rst mid-BLANK -> all reset values on the next edge.
- With SCAN_CTRL_HOLD_EN defined: hold=1 for 10 cycles during ch2 ACTIVE with div=3 -> en stays high for 14 cycles, then normal advance to ch3.
